ff_bank: RTL and testbench

- Parametrised successor to the single-bit toggle flip-flop: a bank of WIDTH flip-flops sharing one clock, reset and enable.
- A run-time mode input selects D, T, JK or SR next-state behaviour for all bits.
- Adds per-bit change pulses, a saturating count of cycles in which the bank changed, and a sticky flag for illegal SR input.
- Intended as a reusable state-register primitive and as a benchmark target for the flip-flop test benches.

---
 rtl/ff_bank.sv | 167 ++++++++++++++++
 tb/tb_ff_bank.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ff_bank.sv
// ff_bank: WIDTH-bit flip-flop bank with run-time D/T/JK/SR mode, change pulses,
// a saturating change counter and a sticky illegal-SR flag. Optional FF_BANK_CNT_CLR_EN adds cnt_clr.
module ff_bank #(
    parameter int                 WIDTH     = 8,
    parameter int                 CNT_W     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef FF_BANK_CNT_CLR_EN
    input  logic             cnt_clr,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] toggled,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             sr_err
);

    localparam logic [1:0]       MODE_D  = 2'b00;
    localparam logic [1:0]       MODE_T  = 2'b01;
    localparam logic [1:0]       MODE_JK = 2'b10;
    localparam logic [1:0]       MODE_SR = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] toggled_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sr_err_r;

    logic [WIDTH-1:0] q_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             chg_s;
    logic             sr_illegal_s;
    logic             clear_s;

    // Next state of one bit; an illegal SR pair (S=R=1) holds the bit.
    function automatic logic next_bit(input logic [1:0] m, input logic qb,
                                      input logic ab, input logic bb);
        logic nb;
        nb = qb;
        case (m)
            MODE_D:  nb = ab;
            MODE_T:  nb = qb ^ ab;
            MODE_JK: begin
                case ({ab, bb})
                    2'b10:   nb = 1'b1;
                    2'b01:   nb = 1'b0;
                    2'b11:   nb = ~qb;
                    default: nb = qb;
                endcase
            end
            MODE_SR: begin
                case ({ab, bb})
                    2'b10:   nb = 1'b1;
                    2'b01:   nb = 1'b0;
                    default: nb = qb;
                endcase
            end
            default: nb = qb;
        endcase
        return nb;
    endfunction

`ifdef FF_BANK_CNT_CLR_EN
    assign clear_s = cnt_clr;
`else
    assign clear_s = 1'b0;
`endif

    // Per-bit next state and illegal-SR detection for the current edge.
    always_comb begin
        q_next_s     = q_r;
        sr_illegal_s = 1'b0;
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                q_next_s[i] = next_bit(mode, q_r[i], a[i], b[i]);
            end
            sr_illegal_s = (mode == MODE_SR) && (|(a & b));
        end else begin
            q_next_s     = q_r;
            sr_illegal_s = 1'b0;
        end
    end

    // Change detection and saturating counter increment.
    always_comb begin
        chg_s      = |(q_next_s ^ q_r);
        cnt_next_s = cnt_r;
        if (chg_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // State registers; reset beats everything, clear beats a same-edge count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_r       <= RESET_VAL;
            toggled_r <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            sr_err_r  <= 1'b0;
        end else begin
            q_r       <= q_next_s;
            toggled_r <= q_next_s ^ q_r;
            if (clear_s) begin
                cnt_r    <= {CNT_W{1'b0}};
                sr_err_r <= 1'b0;
            end else begin
                cnt_r    <= cnt_next_s;
                sr_err_r <= sr_err_r | sr_illegal_s;
            end
        end
    end

    assign q       = q_r;
    assign qn      = ~q_r;
    assign toggled = toggled_r;
    assign chg_cnt = cnt_r;
    assign sr_err  = sr_err_r;

    ff_bank_chk #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chk (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (clear_s),
        .q       (q_r),
        .qn      (qn),
        .toggled (toggled_r),
        .chg_cnt (cnt_r),
        .sr_err  (sr_err_r)
    );

endmodule

// Property checker for ff_bank outputs.
module ff_bank_chk #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             rstn,
    input logic             clear,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] qn,
    input logic [WIDTH-1:0] toggled,
    input logic [CNT_W-1:0] chg_cnt,
    input logic             sr_err
);

    a_qn_inv: assert property (@(posedge clk) disable iff (!rstn) qn == ~q);

    a_reset_clears: assert property (@(posedge clk)
        !rstn |=> (chg_cnt == {CNT_W{1'b0}}) && (toggled == {WIDTH{1'b0}}) && !sr_err);

    a_sr_sticky: assert property (@(posedge clk)
        (rstn && sr_err && !clear) |=> sr_err);

    a_cnt_monotonic: assert property (@(posedge clk)
        (rstn && !clear) |=> (chg_cnt >= $past(chg_cnt)));

endmodule

// File: tb/tb_ff_bank.sv
// Randomized scoreboard bench for ff_bank: a behavioural model predicts every edge,
// the monitor pops predictions on the falling edge and compares against two DUT instances.
module tb_ff_bank;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [7:0] a = 8'hFF;
    logic [7:0] b = 8'h00;
    logic       cnt_clr = 1'b0;

    logic [7:0] q, qn, toggled, q2, qn2, toggled2;
    logic [7:0] chg_cnt;
    logic [1:0] chg_cnt2;
    logic       sr_err, sr_err2;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] tog;
        int         c8;
        int         c2;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    // Reference state
    logic [7:0] m_q;
    int         m_c8, m_c2;
    logic       m_err;

    always #5 clk = ~clk;

    ff_bank #(.WIDTH(8), .CNT_W(8), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .a(a), .b(b),
`ifdef FF_BANK_CNT_CLR_EN
        .cnt_clr(cnt_clr),
`endif
        .q(q), .qn(qn), .toggled(toggled), .chg_cnt(chg_cnt), .sr_err(sr_err)
    );

    ff_bank #(.WIDTH(8), .CNT_W(2), .RESET_VAL(8'hA5)) dut2 (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .a(a), .b(b),
`ifdef FF_BANK_CNT_CLR_EN
        .cnt_clr(cnt_clr),
`endif
        .q(q2), .qn(qn2), .toggled(toggled2), .chg_cnt(chg_cnt2), .sr_err(sr_err2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Apply the specification's rules to the current inputs and return the expected post-edge outputs.
    function automatic exp_t predict();
        exp_t       e;
        logic [7:0] nq;
        logic       ill;
        bit         clr;
`ifdef FF_BANK_CNT_CLR_EN
        clr = cnt_clr;
`else
        clr = 1'b0;
`endif
        if (!rstn) begin
            m_q = 8'hA5; m_c8 = 0; m_c2 = 0; m_err = 1'b0;
            e.tog = 8'h00;
        end else begin
            nq  = m_q;
            ill = 1'b0;
            if (en) begin
                for (int i = 0; i < 8; i++) begin
                    case (mode)
                        2'd0: nq[i] = a[i];
                        2'd1: if (a[i]) nq[i] = !m_q[i];
                        2'd2: begin
                            if (a[i] && b[i]) nq[i] = !m_q[i];
                            else if (a[i]) nq[i] = 1'b1;
                            else if (b[i]) nq[i] = 1'b0;
                        end
                        default: begin
                            if (a[i] && b[i]) ill = 1'b1;
                            else if (a[i]) nq[i] = 1'b1;
                            else if (b[i]) nq[i] = 1'b0;
                        end
                    endcase
                end
            end
            e.tog = nq ^ m_q;
            if (clr) begin
                m_c8 = 0; m_c2 = 0; m_err = 1'b0;
            end else begin
                if (nq != m_q) begin
                    if (m_c8 < 255) m_c8++;
                    if (m_c2 < 3) m_c2++;
                end
                if (ill) m_err = 1'b1;
            end
            m_q = nq;
        end
        e.q = m_q; e.c8 = m_c8; e.c2 = m_c2; e.err = m_err;
        return e;
    endfunction

    task automatic step();
        exp_t e;
        e = predict();
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic drive(input logic r, input logic e_in, input logic [1:0] m,
                         input logic [7:0] av, input logic [7:0] bv);
        rstn = r; en = e_in; mode = m; a = av; b = bv;
        step();
    endtask

    // Monitor: every edge produces an output; compare it with the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("q", {24'd0, q}, {24'd0, e.q});
            chk("qn", {24'd0, qn}, {24'd0, ~e.q});
            chk("toggled", {24'd0, toggled}, {24'd0, e.tog});
            chk("chg_cnt", {24'd0, chg_cnt}, e.c8);
            chk("sr_err", {31'd0, sr_err}, {31'd0, e.err});
            chk("q_w2", {24'd0, q2}, {24'd0, e.q});
            chk("toggled_w2", {24'd0, toggled2}, {24'd0, e.tog});
            chk("chg_cnt_w2", {30'd0, chg_cnt2}, e.c2);
            chk("sr_err_w2", {31'd0, sr_err2}, {31'd0, e.err});
        end
    end

    initial begin
        int budget;
        // Reset with en=1, D mode, a=FF, then release
        drive(1'b0, 1'b1, 2'b00, 8'hFF, 8'h00);
        drive(1'b0, 1'b1, 2'b00, 8'hFF, 8'h00);
        drive(1'b1, 1'b1, 2'b00, 8'hFF, 8'h00);
        // T mode from 00
        drive(1'b1, 1'b1, 2'b00, 8'h00, 8'h00);
        repeat (3) drive(1'b1, 1'b1, 2'b01, 8'h0F, 8'h00);
        drive(1'b1, 1'b1, 2'b01, 8'h00, 8'h00);
        // JK from F0, then hold with en=0
        drive(1'b1, 1'b1, 2'b00, 8'hF0, 8'h00);
        drive(1'b1, 1'b1, 2'b10, 8'b1100_1100, 8'b1010_1010);
        drive(1'b1, 1'b0, 2'b10, 8'b1100_1100, 8'b1010_1010);
        // Illegal SR on bit 0 with legal set on bit 7
        drive(1'b1, 1'b1, 2'b00, 8'h00, 8'h00);
        drive(1'b1, 1'b1, 2'b11, 8'h81, 8'h01);
        drive(1'b1, 1'b1, 2'b00, 8'h00, 8'h00);
        drive(1'b0, 1'b1, 2'b00, 8'h00, 8'h00);
        // Saturation of the narrow counter
        repeat (6) drive(1'b1, 1'b1, 2'b01, 8'h01, 8'h00);
`ifdef FF_BANK_CNT_CLR_EN
        cnt_clr = 1'b1;
        drive(1'b1, 1'b1, 2'b01, 8'h01, 8'h00);
        cnt_clr = 1'b0;
        drive(1'b1, 1'b1, 2'b01, 8'h01, 8'h00);
`endif
        // Randomized traffic with occasional reset, hold and clear
        for (int n = 0; n < 600; n++) begin
`ifdef FF_BANK_CNT_CLR_EN
            cnt_clr = ($urandom_range(0, 24) == 0);
`endif
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) != 0),
                  2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end
        cnt_clr = 1'b0;
        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
